// File: rtl/elevator_scan_ctrl.sv
// Single-car SCAN elevator controller: latches floor requests into a bitmap, serves
// them while keeping direction, models per-floor travel time and a timed door dwell.
module elevator_scan_ctrl #(
   parameter  int NUM_FLOORS    = 8,
   parameter  int TRAVEL_CYCLES = 100,
   parameter  int DOOR_CYCLES   = 50,
   localparam int FLOOR_W       = (NUM_FLOORS > 2) ? $clog2(NUM_FLOORS) : 1,
   localparam int CNT_W         = $clog2(((TRAVEL_CYCLES > DOOR_CYCLES) ? TRAVEL_CYCLES
                                                                         : DOOR_CYCLES) + 1)
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  req_valid,
   input  logic [FLOOR_W-1:0]    req_floor,
   output logic [FLOOR_W-1:0]    current_floor,
   output logic                  up,
   output logic                  down,
   output logic                  stop,
   output logic                  door_open,
   output logic [NUM_FLOORS-1:0] pending,
   output logic [CNT_W-1:0]      counter
);

   typedef enum logic [1:0] {IDLE, MOVE_UP, MOVE_DOWN, DOOR_OPEN} state_t;
   typedef enum logic {DIR_UP, DIR_DOWN} dir_t;

   localparam logic [NUM_FLOORS-1:0] ONE         = NUM_FLOORS'(1);
   localparam logic [CNT_W-1:0]      TRAVEL_LAST = CNT_W'(TRAVEL_CYCLES - 1);
   localparam logic [CNT_W-1:0]      DOOR_LAST   = CNT_W'(DOOR_CYCLES - 1);

   state_t                  state_q, state_d;
   dir_t                    dir_q, dir_d;
   logic [FLOOR_W-1:0]      floor_q, floor_d, floor_step;
   logic [CNT_W-1:0]        cnt_q, cnt_d;
   logic [NUM_FLOORS-1:0]   pend_q, pend_d;
   logic [NUM_FLOORS-1:0]   req_bit, cur_bit, arr_bit, ahead, clr_bit;

   function automatic logic [NUM_FLOORS-1:0] floor_bit(input logic [FLOOR_W-1:0] f);
      return ONE << f;
   endfunction

   function automatic logic [NUM_FLOORS-1:0] below_of(input logic [FLOOR_W-1:0] f);
      return floor_bit(f) - ONE;
   endfunction

   function automatic logic [NUM_FLOORS-1:0] above_of(input logic [FLOOR_W-1:0] f);
      return ~(below_of(f) | floor_bit(f));
   endfunction

   // A floor index outside the car's range shifts the one-hot out entirely,
   // so out-of-range requests vanish without an explicit compare.
   assign req_bit    = req_valid ? floor_bit(req_floor) : '0;
   assign cur_bit    = floor_bit(floor_q);
   assign floor_step = (state_q == MOVE_UP) ? floor_q + FLOOR_W'(1) : floor_q - FLOOR_W'(1);

   always_comb begin
      // NOTE: every variable gets a default first so no path leaves it unassigned
      // and no latch is inferred.
      state_d = state_q;
      dir_d   = dir_q;
      floor_d = floor_q;
      cnt_d   = cnt_q;
      clr_bit = '0;
      arr_bit = '0;
      ahead   = '0;

      unique case (state_q)
         IDLE: begin
            cnt_d = '0;
            if (|pend_q) begin
               if (|(pend_q & cur_bit)) begin
                  state_d = DOOR_OPEN;
                  clr_bit = cur_bit;
               end else if (dir_q == DIR_UP && |(pend_q & above_of(floor_q))) begin
                  state_d = MOVE_UP;
               end else if (|(pend_q & below_of(floor_q))) begin
                  state_d = MOVE_DOWN;
                  dir_d   = DIR_DOWN;
               end else begin
                  state_d = MOVE_UP;
                  dir_d   = DIR_UP;
               end
            end
         end
         MOVE_UP, MOVE_DOWN: begin
            if (cnt_q == TRAVEL_LAST) begin
               floor_d = floor_step;
               cnt_d   = '0;
               arr_bit = floor_bit(floor_step);
               ahead   = (state_q == MOVE_UP) ? above_of(floor_step) : below_of(floor_step);
               if (|(pend_q & arr_bit)) begin
                  state_d = DOOR_OPEN;
                  clr_bit = arr_bit;
               end else if (!(|(pend_q & ahead))) begin
                  state_d = IDLE;
               end
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         DOOR_OPEN: begin
            // A call for this floor while open keeps the door open and is never latched.
            clr_bit = cur_bit;
            if (|(req_bit & cur_bit)) begin
               cnt_d = '0;
            end else if (cnt_q == DOOR_LAST) begin
               state_d = IDLE;
               cnt_d   = '0;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
      endcase

      pend_d = (pend_q | req_bit) & ~clr_bit;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q <= IDLE;
         dir_q   <= DIR_UP;
         floor_q <= '0;
         cnt_q   <= '0;
         pend_q  <= '0;
      end else begin
         // NOTE: non-blocking assignments so every register updates from the
         // same pre-edge values regardless of statement order.
         state_q <= state_d;
         dir_q   <= dir_d;
         floor_q <= floor_d;
         cnt_q   <= cnt_d;
         pend_q  <= pend_d;
      end
   end

   assign current_floor = floor_q;
   assign pending       = pend_q;
   assign counter       = cnt_q;
   assign up            = (state_q == MOVE_UP);
   assign down          = (state_q == MOVE_DOWN);
   assign stop          = (state_q == IDLE) || (state_q == DOOR_OPEN);
   assign door_open     = (state_q == DOOR_OPEN);

endmodule

// File: tb/tb_elevator_scan_ctrl.sv
// Directed bench for elevator_scan_ctrl: 8-floor car for SCAN behaviour and a
// 6-floor car for out-of-range request rejection.
module tb_elevator_scan_ctrl;

   logic       clk;
   logic       reset_n;
   logic       req_valid, req_valid6;
   logic [2:0] req_floor, req_floor6;

   logic [2:0] current_floor, current_floor6;
   logic       up, down, stop, door_open;
   logic       up6, down6, stop6, door_open6;
   logic [7:0] pending;
   logic [5:0] pending6;
   logic [2:0] counter, counter6;

   int checks = 0;
   int errors = 0;

   elevator_scan_ctrl #(.NUM_FLOORS(8), .TRAVEL_CYCLES(4), .DOOR_CYCLES(3)) dut (
      .clk(clk), .reset_n(reset_n), .req_valid(req_valid), .req_floor(req_floor),
      .current_floor(current_floor), .up(up), .down(down), .stop(stop),
      .door_open(door_open), .pending(pending), .counter(counter)
   );

   elevator_scan_ctrl #(.NUM_FLOORS(6), .TRAVEL_CYCLES(4), .DOOR_CYCLES(3)) dut6 (
      .clk(clk), .reset_n(reset_n), .req_valid(req_valid6), .req_floor(req_floor6),
      .current_floor(current_floor6), .up(up6), .down(down6), .stop(stop6),
      .door_open(door_open6), .pending(pending6), .counter(counter6)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic req(input logic [2:0] f);
      req_valid = 1'b1;
      req_floor = f;
      step(1);
      req_valid = 1'b0;
   endtask

   always @(negedge clk) begin
      check("onehot8", 32'($onehot({up, down, stop})), 32'd1);
      check("onehot6", 32'($onehot({up6, down6, stop6})), 32'd1);
   end

   initial begin
      reset_n    = 1'b0;
      req_valid  = 1'b0;
      req_floor  = '0;
      req_valid6 = 1'b0;
      req_floor6 = '0;
      step(2);
      check("rst_floor", current_floor, 0);
      check("rst_pend", pending, 0);
      check("rst_cnt", counter, 0);
      check("rst_stop", {up, down, stop, door_open}, 4'b0010);
      reset_n = 1'b1;

      // Out-of-range requests on the 6-floor car
      req_valid6 = 1'b1; req_floor6 = 3'd7;
      step(1);
      check("oor7_pend", pending6, 0);
      req_floor6 = 3'd6;
      step(1);
      req_valid6 = 1'b0;
      check("oor6_pend", pending6, 0);
      step(1);
      check("oor_stop", stop6, 1);
      req_valid6 = 1'b1; req_floor6 = 3'd5;
      step(1);
      req_valid6 = 1'b0;
      check("top6_pend", pending6, 6'h20);

      // Single request to floor 3
      req(3);
      check("r3_pend", pending, 8'h08);
      check("r3_idle", stop, 1);
      step(1);
      check("r3_up", up, 1);
      check("r3_cnt0", counter, 0);
      step(4);
      check("r3_f1", current_floor, 1);
      check("r3_f1_up", up, 1);
      step(4);
      check("r3_f2", current_floor, 2);
      step(3);
      check("r3_last_up", {up, counter}, {1'b1, 3'd3});
      step(1);
      check("r3_arrive", {current_floor, door_open, stop}, {3'd3, 1'b1, 1'b1});
      check("r3_pend0", pending, 0);
      step(2);
      check("r3_door2", {door_open, counter}, {1'b1, 3'd2});
      step(1);
      check("r3_closed", {door_open, stop}, 2'b01);

      // Serve 6 first, then reverse down to 1
      req(6);
      step(1);
      check("s6_up", up, 1);
      req(1);
      check("s6_pend", pending, 8'h42);
      step(11);
      check("s6_arrive", {current_floor, door_open}, {3'd6, 1'b1});
      check("s6_pend", pending, 8'h02);
      step(3);
      check("s6_idle", {stop, door_open}, 2'b10);
      step(1);
      check("s1_down", {down, counter}, {1'b1, 3'd0});
      step(8);
      check("s1_f4", {current_floor, down}, {3'd4, 1'b1});
      step(12);
      check("s1_arrive", {current_floor, door_open}, {3'd1, 1'b1});
      check("s1_pend0", pending, 0);
      step(3);
      check("s1_idle", stop, 1);

      // Move up to 2, then 7 with 5 inserted while travelling
      req(2);
      step(1);
      check("m2_up", up, 1);
      step(4);
      check("m2_arrive", {current_floor, door_open}, {3'd2, 1'b1});
      step(3);
      req(7);
      step(1);
      check("m7_up", up, 1);
      req(5);
      check("m7_pend", pending, 8'hA0);
      step(11);
      check("m5_arrive", {current_floor, door_open}, {3'd5, 1'b1});
      check("m5_pend", pending, 8'h80);
      step(4);
      check("m5_resume", {current_floor, up}, {3'd5, 1'b1});
      step(8);
      check("m7_arrive", {current_floor, door_open}, {3'd7, 1'b1});
      check("m7_pend0", pending, 0);

      // Same-floor request while door open restarts the dwell
      step(1);
      check("d_cnt1", counter, 1);
      req(7);
      check("d_restart", {door_open, counter}, {1'b1, 3'd0});
      check("d_pend0", pending, 0);
      step(1);
      check("d_still_open", {door_open, counter}, {1'b1, 3'd1});
      step(2);
      check("d_closed", {door_open, stop, pending}, {1'b0, 1'b1, 8'h00});

      // Reset mid-travel drops everything immediately
      req(0);
      req(3);
      step(5);
      check("rt_moving", {current_floor, down}, {3'd6, 1'b1});
      reset_n = 1'b0;
      #1;
      check("rt_floor", current_floor, 0);
      check("rt_pend", pending, 0);
      check("rt_flags", {up, down, stop, door_open}, 4'b0010);
      check("rt_cnt", counter, 0);
      step(1);
      reset_n = 1'b1;
      step(2);
      check("rt_after", {current_floor, stop, pending}, {3'd0, 1'b1, 8'h00});

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
